// File: rtl/color_pkg.sv
// Shared encodings for the color tally block: FSM states, filter indices,
// color classes, and the small pure helpers used by the datapath.
package color_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_GATE     = 2'd2,
        ST_CLASSIFY = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        F_RED   = 2'd0,
        F_GREEN = 2'd1,
        F_BLUE  = 2'd2
    } filter_t;

    typedef enum logic [1:0] {
        C_NONE   = 2'd0,
        C_RED    = 2'd1,
        C_YELLOW = 2'd2,
        C_BLUE   = 2'd3
    } color_t;

    localparam logic [1:0] SEL_RED   = 2'b00;
    localparam logic [1:0] SEL_GREEN = 2'b11;
    localparam logic [1:0] SEL_BLUE  = 2'b01;
    localparam logic [9:0] TALLY_MAX = 10'd1023;

    function automatic logic [1:0] filter_sel(input filter_t f);
        logic [1:0] sel;
        case (f)
            F_RED:   sel = SEL_RED;
            F_GREEN: sel = SEL_GREEN;
            F_BLUE:  sel = SEL_BLUE;
            default: sel = SEL_RED;
        endcase
        return sel;
    endfunction

    function automatic filter_t next_filter(input filter_t f);
        filter_t nxt;
        case (f)
            F_RED:   nxt = F_GREEN;
            F_GREEN: nxt = F_BLUE;
            default: nxt = F_RED;
        endcase
        return nxt;
    endfunction

    function automatic logic [2:0] color_led(input color_t c);
        logic [2:0] one_hot;
        case (c)
            C_RED:    one_hot = 3'b001;
            C_YELLOW: one_hot = 3'b010;
            C_BLUE:   one_hot = 3'b100;
            default:  one_hot = 3'b000;
        endcase
        return one_hot;
    endfunction

    // Priority decision on 17-bit values so g + g/2 cannot overflow.
    function automatic color_t classify(input logic [15:0] r, input logic [15:0] g,
                                        input logic [15:0] b, input logic [15:0] min_count);
        logic [16:0] r17;
        logic [16:0] g17;
        logic [16:0] b17;
        logic [16:0] m17;
        color_t      cls;
        r17 = {1'b0, r};
        g17 = {1'b0, g};
        b17 = {1'b0, b};
        m17 = {1'b0, min_count};
        if ((r17 < m17) && (g17 < m17) && (b17 < m17)) begin
            cls = C_NONE;
        end else if ((b17 >= r17) && (b17 >= g17)) begin
            cls = C_BLUE;
        end else if (r17 > (g17 + (g17 >> 1))) begin
            cls = C_RED;
        end else begin
            cls = C_YELLOW;
        end
        return cls;
    endfunction

    function automatic logic [9:0] tally_next(input logic [9:0] cur, input logic clr,
                                              input logic inc);
        logic [9:0] nxt;
        if (clr) begin
            nxt = inc ? 10'd1 : 10'd0;
        end else if (inc && (cur != TALLY_MAX)) begin
            nxt = cur + 10'd1;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/freq_counter.sv
// Synchronizes the sensor square wave, detects rising edges and counts them
// into a saturating 16-bit counter while gate_en is high.
module freq_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        gate_en,
    input  logic        sensor_in,
    output logic [15:0] count
);

    logic        meta_r;
    logic        sync_r;
    logic        prev_r;
    logic [15:0] count_r;
    logic        rise_s;

    // Two-flop synchronizer followed by one history flop for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= sensor_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise_s = sync_r & ~prev_r;

    // count includes this cycle's edge so the final gated cycle is not lost
    always_comb begin
        count = count_r;
        if (gate_en && rise_s && (count_r != 16'hFFFF)) begin
            count = count_r + 16'd1;
        end else begin
            count = count_r;
        end
    end

    // Saturating edge counter, held at zero outside the gate window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= 16'd0;
        end else if (clear) begin
            count_r <= 16'd0;
        end else begin
            count_r <= count;
        end
    end

endmodule

// File: rtl/color_tally.sv
// Cycles the color sensor through red/green/blue filters, classifies each
// measured object, confirms it over several passes and tallies registrations.
module color_tally
    import color_pkg::*;
#(
    parameter int unsigned GATE_CYCLES   = 1_000_000,
    parameter int unsigned SETTLE_CYCLES = 10_000,
    parameter int unsigned CONFIRM       = 3,
    parameter logic [15:0] MIN_COUNT     = 16'd200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sensor_out,
    input  logic       clear_tally,
    output logic       s2,
    output logic       s3,
    output logic [9:0] freq_for_red,
    output logic [9:0] freq_for_yellow,
    output logic [9:0] freq_for_blue,
    output logic [1:0] color_id,
    output logic       color_valid,
    output logic [2:0] led
);

    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);
    localparam logic [7:0]  CONFIRM_W   = 8'(CONFIRM);

    state_t      state_r;
    filter_t     filt_r;
    logic [31:0] cyc_r;
    logic [15:0] r_r;
    logic [15:0] g_r;
    logic [15:0] b_r;
    logic [15:0] cnt_s;
    logic        gate_en_s;
    color_t      cls_s;
    color_t      prev_cls_r;
    logic [7:0]  run_r;
    logic [7:0]  run_next_s;
    logic        armed_r;
    logic        register_s;
    logic [9:0]  tally_red_r;
    logic [9:0]  tally_yellow_r;
    logic [9:0]  tally_blue_r;

    assign gate_en_s = (state_r == ST_GATE);

    freq_counter u_freq_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (~gate_en_s),
        .gate_en   (gate_en_s),
        .sensor_in (sensor_out),
        .count     (cnt_s)
    );

    // Measurement sequencer: settle, gate and store per filter, then classify
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            filt_r   <= F_RED;
            cyc_r    <= 32'd0;
            r_r      <= 16'd0;
            g_r      <= 16'd0;
            b_r      <= 16'd0;
            {s2, s3} <= SEL_RED;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cyc_r    <= 32'd0;
                    filt_r   <= F_RED;
                    {s2, s3} <= SEL_RED;
                    state_r  <= en ? ST_SETTLE : ST_IDLE;
                end
                ST_SETTLE, ST_GATE: begin
                    if (!en) begin
                        state_r  <= ST_IDLE;
                        cyc_r    <= 32'd0;
                        filt_r   <= F_RED;
                        {s2, s3} <= SEL_RED;
                        r_r      <= 16'd0;
                        g_r      <= 16'd0;
                        b_r      <= 16'd0;
                    end else if ((state_r == ST_SETTLE) && (cyc_r == SETTLE_LAST)) begin
                        cyc_r   <= 32'd0;
                        state_r <= ST_GATE;
                    end else if ((state_r == ST_GATE) && (cyc_r == GATE_LAST)) begin
                        cyc_r <= 32'd0;
                        case (filt_r)
                            F_RED:   r_r <= cnt_s;
                            F_GREEN: g_r <= cnt_s;
                            default: b_r <= cnt_s;
                        endcase
                        if (filt_r == F_BLUE) begin
                            state_r <= ST_CLASSIFY;
                        end else begin
                            filt_r   <= next_filter(filt_r);
                            {s2, s3} <= filter_sel(next_filter(filt_r));
                            state_r  <= ST_SETTLE;
                        end
                    end else begin
                        cyc_r <= cyc_r + 32'd1;
                    end
                end
                ST_CLASSIFY: begin
                    cyc_r    <= 32'd0;
                    filt_r   <= F_RED;
                    {s2, s3} <= SEL_RED;
                    state_r  <= en ? ST_SETTLE : ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    cyc_r    <= 32'd0;
                    filt_r   <= F_RED;
                    {s2, s3} <= SEL_RED;
                end
            endcase
        end
    end

    // Classification, confirm run length and the registration decision
    always_comb begin
        cls_s      = classify(r_r, g_r, b_r, MIN_COUNT);
        run_next_s = 8'd1;
        register_s = 1'b0;
        if (cls_s == prev_cls_r) begin
            run_next_s = (run_r >= CONFIRM_W) ? CONFIRM_W : (run_r + 8'd1);
        end else begin
            run_next_s = 8'd1;
        end
        if ((state_r == ST_CLASSIFY) && (run_next_s == CONFIRM_W) &&
            (cls_s != C_NONE) && armed_r) begin
            register_s = 1'b1;
        end else begin
            register_s = 1'b0;
        end
    end

    // Confirm state, tallies and the registered color outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_cls_r     <= C_NONE;
            run_r          <= 8'd0;
            armed_r        <= 1'b1;
            tally_red_r    <= 10'd0;
            tally_yellow_r <= 10'd0;
            tally_blue_r   <= 10'd0;
            color_id       <= 2'd0;
            color_valid    <= 1'b0;
            led            <= 3'b000;
        end else begin
            color_valid <= register_s;
            if (state_r == ST_CLASSIFY) begin
                prev_cls_r <= cls_s;
                run_r      <= run_next_s;
                if (cls_s == C_NONE) begin
                    armed_r <= 1'b1;
                end else if (register_s) begin
                    armed_r <= 1'b0;
                end else begin
                    armed_r <= armed_r;
                end
            end else begin
                run_r <= run_r;
            end
            if (register_s) begin
                color_id <= cls_s;
                led      <= color_led(cls_s);
            end else begin
                color_id <= color_id;
            end
            tally_red_r    <= tally_next(tally_red_r, clear_tally,
                                         register_s && (cls_s == C_RED));
            tally_yellow_r <= tally_next(tally_yellow_r, clear_tally,
                                         register_s && (cls_s == C_YELLOW));
            tally_blue_r   <= tally_next(tally_blue_r, clear_tally,
                                         register_s && (cls_s == C_BLUE));
        end
    end

    assign freq_for_red    = tally_red_r;
    assign freq_for_yellow = tally_yellow_r;
    assign freq_for_blue   = tally_blue_r;

endmodule

// File: doc/color_tally.md
COLOR_TALLY -- requirements
Module: color_tally

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1_000_000, meaning the clk cycles per filter counting window.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 10_000, meaning the clk cycles discarded after each filter change.
REQ-003 SHALL have parameter CONFIRM, default 3, meaning the consecutive identical classifications needed to register an object.
REQ-004 SHALL have parameter MIN_COUNT, default 16'd200, meaning the minimum per-filter count treated as "object present".
REQ-005 SHALL have ports: clk  in  1  system clock; rst  in  1  reset.
REQ-006 One clock (clk); reset rst is asynchronous and active-low.
REQ-007 SHALL have ports: en  in  1  run enable; sensor_out  in  1  color-sensor square wave, asynchronous to clk.
REQ-008 SHALL have port clear_tally  in  1  one-cycle pulse from the dispensing stage zeroing all tallies.
REQ-009 SHALL have ports: s2, s3  out  1 each  sensor filter select.
REQ-010 SHALL have ports: freq_for_red, freq_for_yellow, freq_for_blue  out  10 each  object tallies driving the dispensing stage.
REQ-011 SHALL have ports: color_id  out  2  last registered color (0 none, 1 red, 2 yellow, 3 blue); color_valid  out  1  one-cycle pulse on each registration.
REQ-012 SHALL have port led  out  3  one-hot of color_id ({blue,yellow,red}), 000 for none.

Function
REQ-013 sensor_out SHALL pass through a 2-flop synchronizer; a rising edge is counted when synced=1 and its previous value=0.
REQ-014 FSM states SHALL be IDLE, SETTLE, GATE and CLASSIFY, with filter index f cycling red(s2s3=00), green(11), blue(01).
REQ-015 IDLE: when en=1, set f=red and go to SETTLE next cycle; when en=0, stay in IDLE with s2s3=00.
REQ-016 SETTLE: count exactly SETTLE_CYCLES cycles with no edges counted, then go to GATE.
REQ-017 GATE: count edges for exactly GATE_CYCLES cycles into a 16-bit counter that saturates at 65535 and does not wrap; store the result as r, g or b per f.
REQ-018 At GATE end, if f is not blue: advance f and go to SETTLE; if f is blue: go to CLASSIFY.
REQ-019 CLASSIFY SHALL last one cycle, evaluated in priority order with 17-bit unsigned arithmetic:
 - none if r, g and b are all < MIN_COUNT;
 - else blue if b>=r and b>=g;
 - else red if r > g+(g>>1);
 - else yellow.
REQ-020 After CLASSIFY: go to SETTLE with f=red when en=1; go to IDLE when en=0.
REQ-021 en falling mid-measurement SHALL abort to IDLE next cycle, discard partial counts, and leave the confirm state untouched.
REQ-022 Confirm logic: if the classification equals the previous one, increment a run counter saturating at CONFIRM; otherwise set the run counter to 1.
REQ-023 Registration SHALL occur on the cycle the run reaches CONFIRM with a non-none class and the armed flag=1; it pulses color_valid, updates color_id, increments the matching tally, and clears armed.
REQ-024 armed SHALL be set by any none classification, so the same object is never counted twice.
REQ-025 Tallies SHALL saturate at 1023.
REQ-026 clear_tally SHALL zero all three tallies next cycle.
REQ-027 If clear_tally and a registration coincide, the cycle after SHALL show the registered color's tally=1 and the others=0.
REQ-028 color_id SHALL hold its value until the next registration.

Reset
REQ-029 rst=0 SHALL asynchronously force:
 - state=IDLE, f=red, s2=s3=0;
 - all counters, r/g/b, run counter and tallies=0;
 - color_id=0, color_valid=0, led=000;
 - armed=1, and the previous-class register=none.

Structure
REQ-030 Filter codes, color codes and state encodings SHALL live in shared package color_pkg.
REQ-031 Synchronizer, edge detect and the saturating gated counter SHALL form sub-module freq_counter (inputs clear and gate_en, 16-bit count output).

Verification
Bench parameters: GATE=100, SETTLE=10, CONFIRM=2, MIN=5.
REQ-032 Red object (period 4 on red filter, 40 on green and blue) for 2 passes -> one color_valid pulse, color_id=1, freq_for_red=1, led=001.
REQ-033 Same red object held for 5 passes -> still exactly one pulse; after one none pass and 2 more red passes -> freq_for_red=2.
REQ-034 Yellow object (r=25, g=20, b=2), then blue object (b=30, r=10, g=10), each followed by a none pass -> tallies red/yellow/blue=0/1/1.
REQ-035 freq_for_red preset to 1023 and another red registered -> stays 1023; clear_tally coinciding with a blue registration -> tallies 0/0/1.
REQ-036 en dropped mid-GATE, then rst pulsed low mid-SETTLE -> IDLE, s2s3=00, all outputs at reset values, no color_valid pulse.
